hc_buffers_arbiter: RTL and testbench

//  Shares one hc_buffers_if read port and one write port among N_REQ accelerator requesters.

---
 rtl/hc_buffers_arbiter_pkg.sv | 40 ++++
 rtl/hc_buffers_if.sv | 23 ++
 rtl/hc_buffers_arbiter_tag_fifo.sv | 51 +++++
 rtl/hc_buffers_arbiter.sv | 133 +++++++++++++
 tb/tb_hc_buffers_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hc_buffers_arbiter_pkg.sv
// Shared types for the hc_buffers request/response channels and the requester arbiter.
// Cache lines, command encodings and arbiter defaults live here.
package hc_buffers_arbiter_pkg;

  localparam int HC_CL_BITS       = 512;
  localparam int HC_ARB_N_REQ     = 4;
  localparam int HC_ARB_TAG_DEPTH = 16;

  typedef logic [7:0]            t_request_cmd_id;
  typedef logic [15:0]           t_request_cmd_offset;
  typedef logic [HC_CL_BITS-1:0] t_cl;

  typedef enum logic [2:0] {
    e_REQUEST_IDLE          = 3'd0,
    e_REQUEST_READ_STREAM   = 3'd1,
    e_REQUEST_READ_INDEXED  = 3'd2,
    e_REQUEST_WRITE_STREAM  = 3'd3,
    e_REQUEST_WRITE_INDEXED = 3'd4
  } t_request_cmd;

  typedef struct packed {
    t_request_cmd        cmd;
    t_request_cmd_id     id;
    t_request_cmd_offset offset;
  } t_request_control;

  typedef struct packed {
    logic full;
  } t_request_status;

  typedef struct packed {
    logic valid;
    t_cl  cl_data;
  } t_buffer_data;

  typedef logic [$clog2(HC_ARB_N_REQ)-1:0] t_arb_tag;

  localparam t_request_control CTL_IDLE = '{cmd: e_REQUEST_IDLE, id: '0, offset: '0};

endpackage

// File: rtl/hc_buffers_if.sv
// Channel bundle between a buffer-manager client and the buffer manager.
// Control and status are separate members so each has exactly one driver.
interface hc_buffers_if;
  import hc_buffers_arbiter_pkg::*;

  t_request_control read_control;
  t_request_status  read_status;
  t_request_control write_control;
  t_request_status  write_status;
  t_buffer_data     tx_buffer_data;
  t_buffer_data     rx_buffer_data;

  modport client (
    output read_control, write_control, tx_buffer_data,
    input  read_status, write_status, rx_buffer_data
  );

  modport manager (
    input  read_control, write_control, tx_buffer_data,
    output read_status, write_status, rx_buffer_data
  );

endinterface

// File: rtl/hc_buffers_arbiter_tag_fifo.sv
// Synchronous FIFO holding the requester index of each read in flight, in issue order.
// DEPTH must be a power of 2 so the pointers wrap without compare logic.
module hc_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/hc_buffers_arbiter.sv
// Shares one hc_buffers read port and one write port among N_REQ requesters with
// independent round-robin arbiters; returned lines are routed back in issue order.
module hc_buffers_arbiter
  import hc_buffers_arbiter_pkg::*;
#(
  parameter int N_REQ     = HC_ARB_N_REQ,
  parameter int TAG_DEPTH = HC_ARB_TAG_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           rd_valid,
  input  logic [N_REQ-1:0]           rd_indexed,
  input  t_request_cmd_id            rd_id     [N_REQ],
  input  t_request_cmd_offset        rd_offset [N_REQ],
  output logic [N_REQ-1:0]           rd_ready,
  output logic [N_REQ-1:0]           rsp_valid,
  output t_cl                        rsp_data,
  input  logic [N_REQ-1:0]           wr_valid,
  input  logic [N_REQ-1:0]           wr_indexed,
  input  t_request_cmd_id            wr_id     [N_REQ],
  input  t_request_cmd_offset        wr_offset [N_REQ],
  input  t_cl                        wr_data   [N_REQ],
  output logic [N_REQ-1:0]           wr_ready,
  hc_buffers_if.client               hc_buf,
  output logic [$clog2(TAG_DEPTH):0] outstanding,
  output logic                       err_orphan
);
  localparam int TW = $clog2(N_REQ);

  typedef struct packed {
    logic          found;
    logic [TW-1:0] idx;
  } t_pick;

  // First requesting index at or after ptr, wrapping modulo N_REQ.
  function automatic t_pick rr_pick(input logic [N_REQ-1:0] req, input logic [TW-1:0] ptr);
    t_pick         p;
    logic [TW-1:0] jj;
    p = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      jj = TW'((int'(ptr) + k) % N_REQ);
      if (req[jj]) begin
        p.found = 1'b1;
        p.idx   = jj;
      end
    end
    return p;
  endfunction

  function automatic logic [TW-1:0] rr_next(input logic [TW-1:0] idx);
    return (idx == TW'(N_REQ - 1)) ? '0 : idx + 1'b1;
  endfunction

  logic [TW-1:0]                rd_ptr;
  logic [TW-1:0]                wr_ptr;
  t_pick                        rd_pick;
  t_pick                        wr_pick;
  t_request_control             rd_ctl_next;
  t_request_control             wr_ctl_next;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic [TW-1:0]                fifo_head;
  logic                         rx_pop;

  // Full check uses the pre-pop count, so a pop never frees a slot in its own cycle.
  always_comb begin
    rd_pick     = rr_pick(rd_valid & {N_REQ{~hc_buf.read_status.full & ~fifo_full}}, rd_ptr);
    wr_pick     = rr_pick(wr_valid & {N_REQ{~hc_buf.write_status.full}}, wr_ptr);
    rd_ready    = '0;
    wr_ready    = '0;
    rd_ctl_next = CTL_IDLE;
    wr_ctl_next = CTL_IDLE;
    if (rd_pick.found) begin
      rd_ready[rd_pick.idx] = 1'b1;
      rd_ctl_next.cmd    = rd_indexed[rd_pick.idx] ? e_REQUEST_READ_INDEXED : e_REQUEST_READ_STREAM;
      rd_ctl_next.id     = rd_id[rd_pick.idx];
      rd_ctl_next.offset = rd_offset[rd_pick.idx];
    end
    if (wr_pick.found) begin
      wr_ready[wr_pick.idx] = 1'b1;
      wr_ctl_next.cmd    = wr_indexed[wr_pick.idx] ? e_REQUEST_WRITE_INDEXED : e_REQUEST_WRITE_STREAM;
      wr_ctl_next.id     = wr_id[wr_pick.idx];
      wr_ctl_next.offset = wr_indexed[wr_pick.idx] ? wr_offset[wr_pick.idx] : '0;
    end
  end

  assign rx_pop = hc_buf.rx_buffer_data.valid & ~fifo_empty;

  hc_tag_fifo #(
    .WIDTH (TW),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rd_pick.found),
    .push_data (rd_pick.idx),
    .pop       (rx_pop),
    .pop_data  (fifo_head),
    .count     (outstanding),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr                 <= '0;
      wr_ptr                 <= '0;
      hc_buf.read_control    <= CTL_IDLE;
      hc_buf.write_control   <= CTL_IDLE;
      hc_buf.tx_buffer_data  <= '0;
      rsp_valid              <= '0;
      rsp_data               <= '0;
      err_orphan             <= 1'b0;
    end else begin
      hc_buf.read_control         <= rd_ctl_next;
      hc_buf.write_control        <= wr_ctl_next;
      hc_buf.tx_buffer_data.valid <= wr_pick.found;
      if (rd_pick.found) rd_ptr <= rr_next(rd_pick.idx);
      if (wr_pick.found) begin
        wr_ptr                        <= rr_next(wr_pick.idx);
        hc_buf.tx_buffer_data.cl_data <= wr_data[wr_pick.idx];
      end
      rsp_valid <= '0;
      if (rx_pop) begin
        rsp_valid[fifo_head] <= 1'b1;
        rsp_data             <= hc_buf.rx_buffer_data.cl_data;
      end
      // A line with no read in flight cannot be routed; drop it and flag.
      if (hc_buf.rx_buffer_data.valid && fifo_empty) err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hc_buffers_arbiter.sv
// Scoreboard bench for hc_buffers_arbiter: a queue-based reference model predicts
// grants, commands and routed responses; a separate monitor checks DUT outputs.
module tb_hc_buffers_arbiter;
  import hc_buffers_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int TD = 16;

  logic                clk = 1'b0;
  logic                reset;
  logic [N-1:0]        rd_valid, rd_indexed, rd_ready, rsp_valid;
  logic [N-1:0]        wr_valid, wr_indexed, wr_ready;
  t_request_cmd_id     rd_id [N];
  t_request_cmd_id     wr_id [N];
  t_request_cmd_offset rd_offset [N];
  t_request_cmd_offset wr_offset [N];
  t_cl                 wr_data [N];
  t_cl                 rsp_data;
  logic [4:0]          outstanding;
  logic                err_orphan;

  hc_buffers_if hc_buf();

  hc_buffers_arbiter #(.N_REQ(N), .TAG_DEPTH(TD)) dut (
    .clk         (clk),
    .reset       (reset),
    .rd_valid    (rd_valid),
    .rd_indexed  (rd_indexed),
    .rd_id       (rd_id),
    .rd_offset   (rd_offset),
    .rd_ready    (rd_ready),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .wr_valid    (wr_valid),
    .wr_indexed  (wr_indexed),
    .wr_id       (wr_id),
    .wr_offset   (wr_offset),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .hc_buf      (hc_buf),
    .outstanding (outstanding),
    .err_orphan  (err_orphan)
  );

  always #5 clk = ~clk;

  typedef struct { int stamp; t_request_control ctl; }             rd_exp_t;
  typedef struct { int stamp; t_request_control ctl; t_cl data; }  wr_exp_t;
  typedef struct { int stamp; int who; t_cl data; }                rsp_exp_t;

  rd_exp_t  rd_q[$];
  wr_exp_t  wr_q[$];
  rsp_exp_t rsp_q[$];
  int       tag_q[$];
  int       rd_ptr_m = 0;
  int       wr_ptr_m = 0;
  bit       orphan_m = 0;
  bit       model_en = 0;
  bit       mon_en   = 0;
  int       cyc      = 0;
  int       n_vec    = 0;
  int       n_mis    = 0;

  task automatic chk(input string name, input t_cl act, input t_cl exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic missing(input string name);
    n_vec++;
    n_mis++;
    $display("FAIL %s cyc=%0d got=none want=output", name, cyc);
  endtask

  task automatic unexpected(input string name);
    n_vec++;
    n_mis++;
    $display("FAIL %s cyc=%0d got=output want=none", name, cyc);
  endtask

  function automatic t_cl rand_cl();
    t_cl v;
    for (int i = 0; i < HC_CL_BITS / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Reference model: evaluates the cycle's inputs and predicts next-edge outputs.
  task automatic model_step();
    int           rw, ww, j;
    logic [N-1:0] exp_rr, exp_wr;
    rd_exp_t      re;
    wr_exp_t      we;
    rsp_exp_t     se;
    chk("outstanding", t_cl'(outstanding), t_cl'(tag_q.size()));
    chk("err_orphan", t_cl'(err_orphan), t_cl'(orphan_m));
    rw = -1;
    ww = -1;
    for (int o = 0; o < N; o++) begin
      j = (rd_ptr_m + o) % N;
      if (rw < 0 && rd_valid[j] && !hc_buf.read_status.full && tag_q.size() < TD) rw = j;
      j = (wr_ptr_m + o) % N;
      if (ww < 0 && wr_valid[j] && !hc_buf.write_status.full) ww = j;
    end
    exp_rr = '0;
    exp_wr = '0;
    if (rw >= 0) exp_rr[rw] = 1'b1;
    if (ww >= 0) exp_wr[ww] = 1'b1;
    chk("rd_ready", t_cl'(rd_ready), t_cl'(exp_rr));
    chk("wr_ready", t_cl'(wr_ready), t_cl'(exp_wr));
    if (hc_buf.rx_buffer_data.valid) begin
      if (tag_q.size() == 0) orphan_m = 1;
      else begin
        se.stamp = cyc + 1;
        se.who   = tag_q.pop_front();
        se.data  = hc_buf.rx_buffer_data.cl_data;
        rsp_q.push_back(se);
      end
    end
    if (rw >= 0) begin
      re.stamp      = cyc + 1;
      re.ctl.cmd    = rd_indexed[rw] ? e_REQUEST_READ_INDEXED : e_REQUEST_READ_STREAM;
      re.ctl.id     = rd_id[rw];
      re.ctl.offset = rd_offset[rw];
      rd_q.push_back(re);
      tag_q.push_back(rw);
      rd_ptr_m = (rw + 1) % N;
    end
    if (ww >= 0) begin
      we.stamp      = cyc + 1;
      we.ctl.cmd    = wr_indexed[ww] ? e_REQUEST_WRITE_INDEXED : e_REQUEST_WRITE_STREAM;
      we.ctl.id     = wr_id[ww];
      we.ctl.offset = wr_indexed[ww] ? wr_offset[ww] : '0;
      we.data       = wr_data[ww];
      wr_q.push_back(we);
      wr_ptr_m = (ww + 1) % N;
    end
  endtask

  task automatic monitor_step();
    rd_exp_t      re;
    wr_exp_t      we;
    rsp_exp_t     se;
    logic [N-1:0] oh;
    if (hc_buf.read_control.cmd !== e_REQUEST_IDLE) begin
      if (rd_q.size() == 0) unexpected("rd_cmd");
      else begin
        re = rd_q.pop_front();
        chk("rd_cmd_cycle", t_cl'(cyc), t_cl'(re.stamp));
        chk("rd_cmd", t_cl'(hc_buf.read_control), t_cl'(re.ctl));
      end
    end else begin
      chk("rd_idle_fields", t_cl'({hc_buf.read_control.id, hc_buf.read_control.offset}), '0);
      if (rd_q.size() > 0 && rd_q[0].stamp <= cyc) begin
        re = rd_q.pop_front();
        missing("rd_cmd");
      end
    end
    if (hc_buf.write_control.cmd !== e_REQUEST_IDLE) begin
      if (wr_q.size() == 0) unexpected("wr_cmd");
      else begin
        we = wr_q.pop_front();
        chk("wr_cmd_cycle", t_cl'(cyc), t_cl'(we.stamp));
        chk("wr_cmd", t_cl'(hc_buf.write_control), t_cl'(we.ctl));
        chk("tx_valid", t_cl'(hc_buf.tx_buffer_data.valid), t_cl'(1'b1));
        chk("tx_data", hc_buf.tx_buffer_data.cl_data, we.data);
      end
    end else begin
      chk("tx_valid_idle", t_cl'(hc_buf.tx_buffer_data.valid), '0);
      if (wr_q.size() > 0 && wr_q[0].stamp <= cyc) begin
        we = wr_q.pop_front();
        missing("wr_cmd");
      end
    end
    if (rsp_valid !== '0) begin
      if (rsp_q.size() == 0) unexpected("rsp");
      else begin
        se = rsp_q.pop_front();
        oh = '0;
        oh[se.who] = 1'b1;
        chk("rsp_cycle", t_cl'(cyc), t_cl'(se.stamp));
        chk("rsp_valid", t_cl'(rsp_valid), t_cl'(oh));
        chk("rsp_data", rsp_data, se.data);
      end
    end else if (rsp_q.size() > 0 && rsp_q[0].stamp <= cyc) begin
      se = rsp_q.pop_front();
      missing("rsp");
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #2;
    if (mon_en) monitor_step();
  end

  initial forever begin
    @(posedge clk);
    #3;
    if (reset) begin
      tag_q.delete();
      rd_ptr_m = 0;
      wr_ptr_m = 0;
      orphan_m = 0;
      model_en = 1;
      mon_en   = 1;
    end else if (model_en) begin
      model_step();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rd_valid = '0;
    wr_valid = '0;
    hc_buf.read_status.full        = 1'b0;
    hc_buf.write_status.full       = 1'b0;
    hc_buf.rx_buffer_data.valid    = 1'b0;
  endtask

  task automatic rand_fields();
    rd_indexed = N'($urandom);
    wr_indexed = N'($urandom);
    for (int i = 0; i < N; i++) begin
      rd_id[i]     = 8'($urandom);
      wr_id[i]     = 8'($urandom);
      rd_offset[i] = 16'($urandom);
      wr_offset[i] = 16'($urandom);
      wr_data[i]   = rand_cl();
    end
    hc_buf.rx_buffer_data.cl_data = rand_cl();
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && tag_q.size() > 0; i++) begin
      hc_buf.rx_buffer_data.valid   = 1'b1;
      hc_buf.rx_buffer_data.cl_data = rand_cl();
      step();
    end
    hc_buf.rx_buffer_data.valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    rand_fields();
    repeat (3) step();
    reset = 1'b0;

    // quiet after reset
    repeat (20) step();

    // all requesters streaming: grants rotate 0,1,2,3
    rand_fields();
    rd_indexed = '0;
    rd_valid   = '1;
    repeat (8) step();
    rd_valid = '0;
    drain();
    step();

    // requester 2 indexed read, line returned a few cycles later
    rd_valid      = 4'b0100;
    rd_indexed[2] = 1'b1;
    rd_id[2]      = 8'd3;
    rd_offset[2]  = 16'd5;
    step();
    rd_valid = '0;
    repeat (3) step();
    hc_buf.rx_buffer_data.valid   = 1'b1;
    hc_buf.rx_buffer_data.cl_data = {64{8'hAB}};
    step();
    hc_buf.rx_buffer_data.valid = 1'b0;
    repeat (2) step();

    // fill the tag FIFO, then a single return
    rand_fields();
    rd_valid = '1;
    repeat (20) step();
    hc_buf.rx_buffer_data.valid = 1'b1;
    step();
    hc_buf.rx_buffer_data.valid = 1'b0;
    repeat (3) step();
    rd_valid = '0;
    drain();
    step();

    // write backpressure
    rand_fields();
    wr_valid   = 4'b0010;
    wr_indexed = '0;
    hc_buf.write_status.full = 1'b1;
    repeat (5) step();
    hc_buf.write_status.full = 1'b0;
    step();
    wr_valid = '0;
    step();

    // random traffic
    for (int c = 0; c < 400; c++) begin
      rand_fields();
      rd_valid = N'($urandom);
      wr_valid = N'($urandom);
      hc_buf.read_status.full     = ($urandom_range(7) == 0);
      hc_buf.write_status.full    = ($urandom_range(7) == 0);
      hc_buf.rx_buffer_data.valid = (tag_q.size() > 0) && ($urandom_range(2) == 0);
      step();
    end
    idle_inputs();
    drain();
    step();

    // orphan return after reset
    reset = 1'b1;
    step();
    reset = 1'b0;
    hc_buf.rx_buffer_data.valid = 1'b1;
    step();
    hc_buf.rx_buffer_data.valid = 1'b0;
    repeat (2) step();

    // reset with reads in flight, then a stale return
    rd_valid = '1;
    repeat (3) step();
    rd_valid = '0;
    reset    = 1'b1;
    step();
    reset = 1'b0;
    repeat (2) step();
    hc_buf.rx_buffer_data.valid = 1'b1;
    step();
    hc_buf.rx_buffer_data.valid = 1'b0;
    repeat (3) step();

    chk("rd_q_left", t_cl'(rd_q.size()), '0);
    chk("wr_q_left", t_cl'(wr_q.size()), '0);
    chk("rsp_q_left", t_cl'(rsp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
